// File: rtl/mips_encode.sv
// Streaming MIPS instruction encoder with an output FIFO.
// Ports: clk, reset (sync, active-low), in_valid/in_ready + descriptor
// (mnemonic, rs, rt, rd, imm, target), out_valid/out_ready + out_word/out_addr,
// err (one-cycle reject pulse), err_count (saturating reject count).
module mips_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h00400000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  mnemonic,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]        a_q;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [31:0]        mem_word [DEPTH];
    logic [31:0]        mem_addr [DEPTH];

    logic [31:0]        enc_word;
    logic               bad;
    logic [31:0]        ap4;
    logic [31:0]        d;
    logic               br_ok;
    logic               j_ok;
    logic               accept;
    logic               push;
    logic               pop;
    logic               reject;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_word  = mem_word[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];

    assign accept = in_valid && in_ready;
    assign push   = accept && !bad;
    assign reject = accept && bad;
    assign pop    = out_valid && out_ready;

    // Branch offset is relative to the delay-slot address A+4 and must
    // fit the signed 18-bit byte range the 16-bit word field can express.
    assign ap4   = a_q + 32'd4;
    assign d     = target - ap4;
    assign br_ok = (target[1:0] == 2'b00)
                && ($signed(d) >= -32'sd131072)
                && ($signed(d) <= 32'sd131068);
    assign j_ok  = (target[1:0] == 2'b00)
                && (target[31:28] == ap4[31:28]);

    always_comb begin
        enc_word = '0;
        bad      = 1'b0;
        unique case (mnemonic)
            5'd0:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h20};
            5'd1:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h21};
            5'd2:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h22};
            5'd3:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h24};
            5'd4:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h25};
            5'd5:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h27};
            5'd6:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h26};
            5'd7:  enc_word = {6'h08, rs, rt, imm};
            5'd8:  enc_word = {6'h09, rs, rt, imm};
            5'd9:  enc_word = {6'h0c, rs, rt, imm};
            5'd10: enc_word = {6'h0d, rs, rt, imm};
            5'd11: enc_word = {6'h0e, rs, rt, imm};
            5'd12: begin
                enc_word = {6'h04, rs, rt, d[17:2]};
                bad      = !br_ok;
            end
            5'd13: begin
                enc_word = {6'h05, rs, rt, d[17:2]};
                bad      = !br_ok;
            end
            5'd14: begin
                enc_word = {6'h02, target[27:2]};
                bad      = !j_ok;
            end
            5'd15: enc_word = {6'h00, rs, 15'b0, 6'h08};
            5'd16: enc_word = {6'h0f, 5'b0, rt, imm};
            5'd17: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h2a};
            5'd18: enc_word = {6'h23, rs, rt, imm};
            5'd19: enc_word = {6'h24, rs, rt, imm};
            5'd20: enc_word = {6'h2b, rs, rt, imm};
            5'd21: enc_word = {6'h28, rs, rt, imm};
            5'd22: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h2c};
            default: bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q       <= BASE_ADDR;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                a_q    <= a_q + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            err <= reject;
            if (reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Storage needs no reset: entries are only visible behind count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= enc_word;
            mem_addr[wr_ptr] <= a_q;
        end
    end

endmodule
